// File: rtl/aqua_btb_param_if.sv
// Fetch-lookup and BRU-update bundle for the aqua_btb_param branch target buffer.
// The master is the fetch/BRU side and the slave is the BTB.
interface aqua_btb_param_if #(
    parameter int LOOKUP_N = 2,
    parameter int UPD_N    = 2
);
    logic                    flush;
    logic [LOOKUP_N*32-1:0]  lookup_pc;
    logic [LOOKUP_N-1:0]     pred_hit;
    logic [LOOKUP_N-1:0]     pred_taken;
    logic [LOOKUP_N*32-1:0]  pred_target;
    logic [UPD_N-1:0]        upd_en;
    logic [UPD_N*32-1:0]     upd_pc;
    logic [UPD_N*32-1:0]     upd_target;
    logic [UPD_N-1:0]        upd_taken;

    modport master (
        output flush, lookup_pc, upd_en, upd_pc, upd_target, upd_taken,
        input  pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  flush, lookup_pc, upd_en, upd_pc, upd_target, upd_taken,
        output pred_hit, pred_taken, pred_target
    );
endinterface

// File: rtl/aqua_btb_param.sv
// Direct-mapped tagged BTB with a 2-bit bimodal counter per entry.
// Optional macro AQUA_BTB_BYPASS_EN forwards same-cycle updates to the lookup ports.
module aqua_btb_param #(
    parameter int DEPTH    = 64,
    parameter int LOOKUP_N = 2,
    parameter int UPD_N    = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    aqua_btb_param_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = 30 - IDX_W;

    typedef logic [1:0] predictor_t;
    localparam predictor_t NN = 2'b00;
    localparam predictor_t NT = 2'b01;
    localparam predictor_t TN = 2'b10;
    localparam predictor_t TT = 2'b11;

    logic             valid_q  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [31:0]      target_q [DEPTH];
    predictor_t       cnt_q    [DEPTH];

    logic [IDX_W-1:0] upd_idx    [UPD_N];
    logic [TAG_W-1:0] upd_tag    [UPD_N];
    logic [31:0]      nxt_target [UPD_N];
    predictor_t       nxt_cnt    [UPD_N];
    logic [UPD_N-1:0] upd_win;
    logic [UPD_N-1:0] upd_wr;
    logic             unused_pc_lsb;

    always_comb begin
        for (int p = 0; p < UPD_N; p++) begin
            upd_idx[p] = bus.upd_pc[32*p+2 +: IDX_W];
            upd_tag[p] = bus.upd_pc[32*p+IDX_W+2 +: TAG_W];
        end
    end

    // A port only wins its index when no younger (higher) enabled port targets the same index.
    always_comb begin
        for (int p = 0; p < UPD_N; p++) begin
            logic hit;
            logic taken;
            predictor_t cnt;
            upd_win[p] = bus.upd_en[p];
            for (int q = p + 1; q < UPD_N; q++) begin
                if (bus.upd_en[q] && (upd_idx[q] == upd_idx[p])) begin
                    upd_win[p] = 1'b0;
                end
            end
            hit   = valid_q[upd_idx[p]] && (tag_q[upd_idx[p]] == upd_tag[p]);
            taken = bus.upd_taken[p];
            cnt   = cnt_q[upd_idx[p]];
            upd_wr[p]     = upd_win[p] && (hit || taken);
            nxt_target[p] = taken ? bus.upd_target[32*p +: 32] : target_q[upd_idx[p]];
            if (!hit) begin
                nxt_cnt[p] = TN;
            end else if (taken) begin
                nxt_cnt[p] = (cnt == TT) ? TT : cnt + 2'd1;
            end else begin
                nxt_cnt[p] = (cnt == NN) ? NN : cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= NT;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            for (int p = 0; p < UPD_N; p++) begin
                if (upd_wr[p]) begin
                    valid_q[upd_idx[p]]  <= 1'b1;
                    tag_q[upd_idx[p]]    <= upd_tag[p];
                    target_q[upd_idx[p]] <= nxt_target[p];
                    cnt_q[upd_idx[p]]    <= nxt_cnt[p];
                end
            end
        end
    end

    always_comb begin
        bus.pred_hit    = '0;
        bus.pred_taken  = '0;
        bus.pred_target = '0;
        for (int k = 0; k < LOOKUP_N; k++) begin
            logic [IDX_W-1:0] lk_idx;
            logic [TAG_W-1:0] lk_tag;
            logic             e_valid;
            logic [TAG_W-1:0] e_tag;
            logic [31:0]      e_target;
            predictor_t       e_cnt;
            logic             hit;
            lk_idx   = bus.lookup_pc[32*k+2 +: IDX_W];
            lk_tag   = bus.lookup_pc[32*k+IDX_W+2 +: TAG_W];
            e_valid  = valid_q[lk_idx];
            e_tag    = tag_q[lk_idx];
            e_target = target_q[lk_idx];
            e_cnt    = cnt_q[lk_idx];
`ifdef AQUA_BTB_BYPASS_EN
            // At most one writing port wins a given index, so the order of this scan is irrelevant.
            for (int p = 0; p < UPD_N; p++) begin
                if (upd_wr[p] && (upd_idx[p] == lk_idx)) begin
                    e_valid  = 1'b1;
                    e_tag    = upd_tag[p];
                    e_target = nxt_target[p];
                    e_cnt    = nxt_cnt[p];
                end
            end
            if (bus.flush) begin
                e_valid = 1'b0;
            end
`endif
            hit                     = e_valid && (e_tag == lk_tag);
            bus.pred_hit[k]         = hit;
            bus.pred_taken[k]       = hit && e_cnt[1];
            bus.pred_target[32*k +: 32] = hit ? e_target : 32'h0;
        end
    end

    always_comb begin
        unused_pc_lsb = 1'b0;
        for (int k = 0; k < LOOKUP_N; k++) begin
            unused_pc_lsb = unused_pc_lsb ^ (^bus.lookup_pc[32*k +: 2]);
        end
        for (int p = 0; p < UPD_N; p++) begin
            unused_pc_lsb = unused_pc_lsb ^ (^bus.upd_pc[32*p +: 2]);
        end
    end
endmodule
